// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one instruction-memory
// request at a time, parks a returned word while fetch is stalled, squashes
// in-flight responses on a redirect, and drives the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  // hazard unit
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  // redirect from execute
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  // IF/ID register
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        FetchBusy
);

  typedef enum logic [1:0] {
    StFetch,  // request outstanding at pcf_q
    StHold,   // word parked in the hold buffer, no request
    StKill    // stale request outstanding at kill_addr_q, response dropped
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pcf_plus4;
  // address of the request being squashed; must stay on the bus until ack
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  // word handed to IF/ID this cycle (unless flushed or stalled)
  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] deliver_pc;

  logic [31:0] instr_d, pc_d, pc_plus4_d;

  // wraps naturally at 2^32
  assign pcf_plus4 = pcf_q + 32'd4;

  // Fetch control: next state, next PC, hold buffer and delivery select.
  always_comb begin
    state_d       = state_q;
    pcf_d         = pcf_q;
    kill_addr_d   = kill_addr_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    deliver       = 1'b0;
    deliver_instr = hold_instr_q;
    deliver_pc    = hold_pc_q;

    unique case (state_q)
      StFetch: begin
        if (PCSrcE) begin
          // redirect wins over stall; an acked word is simply dropped
          pcf_d = PCTargetE;
          if (!imem_ack) begin
            // request still in flight: keep presenting it until it retires
            kill_addr_d = pcf_q;
            state_d     = StKill;
          end
        end else if (imem_ack) begin
          if (StallF) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pcf_q;
            state_d      = StHold;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            deliver_pc    = pcf_q;
            pcf_d         = pcf_plus4;
          end
        end
      end

      StHold: begin
        if (PCSrcE) begin
          pcf_d   = PCTargetE;
          state_d = StFetch;
        end else if (!StallF) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_q;
          deliver_pc    = hold_pc_q;
          pcf_d         = pcf_plus4;
          state_d       = StFetch;
        end
      end

      StKill: begin
        // further redirects only retarget; the stale request must still retire
        if (PCSrcE) begin
          pcf_d = PCTargetE;
        end
        if (imem_ack) begin
          state_d = StFetch;
        end
      end

      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // Memory request and busy indication; silenced while reset is held.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pcf_q;
    FetchBusy = 1'b0;
    if (!rst) begin
      imem_req  = (state_q != StHold);
      FetchBusy = (state_q != StFetch);
    end
    if (state_q == StKill) begin
      imem_addr = kill_addr_q;
    end
  end

  // IF/ID next value: flush, then stall, then delivery, else bubble.
  always_comb begin
    instr_d    = NOP_INSTR;
    pc_d       = 32'd0;
    pc_plus4_d = 32'd0;
    if (FlushD) begin
      instr_d    = NOP_INSTR;
      pc_d       = 32'd0;
      pc_plus4_d = 32'd0;
    end else if (StallD) begin
      instr_d    = instrD;
      pc_d       = PCD;
      pc_plus4_d = PCPlus4D;
    end else if (deliver) begin
      instr_d    = deliver_instr;
      pc_d       = deliver_pc;
      pc_plus4_d = deliver_pc + 32'd4;
    end
  end

  // Fetch state, PC, squash address and hold buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFetch;
      pcf_q        <= RESET_PC;
      kill_addr_q  <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      kill_addr_q  <= kill_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
    end else begin
      instrD   <= instr_d;
      PCD      <= pc_d;
      PCPlus4D <= pc_plus4_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle step drives hazard/memory inputs,
// checks the request side before the edge and the IF/ID register after it.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int KDel = 0;  // expect delivery of word at dpc
  localparam int KBub = 1;  // expect bubble
  localparam int KHld = 2;  // expect IF/ID frozen

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic        clk, rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instrD, PCD, PCPlus4D;
  logic        FetchBusy;

  int   vectors = 0;
  int   errors  = 0;
  exp_t sb[$];
  exp_t last_exp;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instrD     (instrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .FetchBusy  (FetchBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input string tag, input logic exp_req, input logic [31:0] exp_addr,
                      input logic exp_busy, input logic ack, input logic sf, input logic sd,
                      input logic fd, input logic ps, input logic [31:0] tgt,
                      input int kind, input logic [31:0] dpc);
    exp_t e;
    exp_t got;
    StallF     = sf;
    StallD     = sd;
    FlushD     = fd;
    PCSrcE     = ps;
    PCTargetE  = tgt;
    imem_ack   = ack;
    imem_rdata = ack ? mem_word(exp_addr) : 32'hdead_beef;
    case (kind)
      KDel:    e = '{mem_word(dpc), dpc, dpc + 32'd4};
      KBub:    e = '{NOP, 32'd0, 32'd0};
      default: e = last_exp;
    endcase
    last_exp = e;
    sb.push_back(e);
    #1;
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) chk({tag, ".addr"}, imem_addr, exp_addr);
    chk({tag, ".busy"}, {31'd0, FetchBusy}, {31'd0, exp_busy});
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".instrD"}, instrD, got.instr);
    chk({tag, ".PCD"}, PCD, got.pc);
    chk({tag, ".PCPlus4D"}, PCPlus4D, got.pc4);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
    PCTargetE = 0; imem_ack = 0; imem_rdata = 0;
    last_exp = '{NOP, 32'd0, 32'd0};
    #1;
    chk("rst.req", {31'd0, imem_req}, 32'd0);
    chk("rst.busy", {31'd0, FetchBusy}, 32'd0);
    chk("rst.instrD", instrD, NOP);
    chk("rst.PCD", PCD, 32'd0);
    chk("rst.PCPlus4D", PCPlus4D, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // zero-wait streaming
    step("z0",  1, 32'h0,  0, 1, 0, 0, 0, 0, 0, KDel, 32'h0);
    step("z4",  1, 32'h4,  0, 1, 0, 0, 0, 0, 0, KDel, 32'h4);
    step("z8",  1, 32'h8,  0, 1, 0, 0, 0, 0, 0, KDel, 32'h8);
    step("zc",  1, 32'hc,  0, 1, 0, 0, 0, 0, 0, KDel, 32'hc);
    // ack at 0x10 under StallF/StallD for three cycles
    step("st0", 1, 32'h10, 0, 1, 1, 1, 0, 0, 0, KHld, 0);
    step("st1", 0, 32'h10, 1, 0, 1, 1, 0, 0, 0, KHld, 0);
    step("st2", 0, 32'h10, 1, 0, 1, 1, 0, 0, 0, KHld, 0);
    step("rel", 0, 32'h10, 1, 0, 0, 0, 0, 0, 0, KDel, 32'h10);
    // two wait states at 0x14
    step("w0",  1, 32'h14, 0, 0, 0, 0, 0, 0, 0, KBub, 0);
    step("w1",  1, 32'h14, 0, 0, 0, 0, 0, 0, 0, KBub, 0);
    step("w2",  1, 32'h14, 0, 1, 0, 0, 0, 0, 0, KDel, 32'h14);
    step("s18", 1, 32'h18, 0, 1, 0, 0, 0, 0, 0, KDel, 32'h18);
    step("s1c", 1, 32'h1c, 0, 1, 0, 0, 0, 0, 0, KDel, 32'h1c);
    // redirect to 0x80 while 0x20 pending
    step("rd",  1, 32'h20, 0, 0, 0, 0, 0, 1, 32'h80, KBub, 0);
    step("k0",  1, 32'h20, 1, 0, 0, 0, 0, 0, 0, KBub, 0);
    step("k1",  1, 32'h20, 1, 1, 0, 0, 0, 0, 0, KBub, 0);
    step("t80", 1, 32'h80, 0, 1, 0, 0, 0, 0, 0, KDel, 32'h80);
    // flush coincident with delivery; PC still advances
    step("fl",  1, 32'h84, 0, 1, 0, 0, 1, 0, 0, KBub, 0);
    step("a88", 1, 32'h88, 0, 1, 0, 0, 0, 0, 0, KDel, 32'h88);
    // redirect with ack in FETCH, then redirect again during KILL
    step("rda", 1, 32'h8c,  0, 1, 0, 0, 0, 1, 32'h200, KBub, 0);
    step("rk",  1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h300, KBub, 0);
    step("rkk", 1, 32'h200, 1, 0, 0, 0, 0, 1, 32'h400, KBub, 0);
    step("rka", 1, 32'h200, 1, 1, 0, 0, 0, 0, 0, KBub, 0);
    step("t400", 1, 32'h400, 0, 1, 0, 0, 0, 0, 0, KDel, 32'h400);
    // redirect while holding a word
    step("hst", 1, 32'h404, 0, 1, 1, 1, 0, 0, 0, KHld, 0);
    step("hrd", 0, 32'h404, 1, 0, 1, 0, 0, 1, 32'hffff_fff8, KBub, 0);
    // address wrap
    step("wf8", 1, 32'hffff_fff8, 0, 1, 0, 0, 0, 0, 0, KDel, 32'hffff_fff8);
    step("wfc", 1, 32'hffff_fffc, 0, 1, 0, 0, 0, 0, 0, KDel, 32'hffff_fffc);

    // reset pulse mid-wait at 0x0
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; imem_ack = 0;
    #1;
    chk("pre.req", {31'd0, imem_req}, 32'd1);
    chk("pre.addr", imem_addr, 32'h0);
    rst = 1'b1;
    #1;
    chk("mid.req", {31'd0, imem_req}, 32'd0);
    chk("mid.busy", {31'd0, FetchBusy}, 32'd0);
    chk("mid.instrD", instrD, NOP);
    chk("mid.PCD", PCD, 32'd0);
    chk("mid.PCPlus4D", PCPlus4D, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_exp = '{NOP, 32'd0, 32'd0};
    step("r0", 1, 32'h0, 0, 1, 0, 0, 0, 0, 0, KDel, 32'h0);
    step("r4", 1, 32'h4, 0, 1, 0, 0, 0, 0, 0, KDel, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
